// File: rtl/life_manager.sv
// -----------------------------------------------------------------------------
// life_manager
//
// Tracks the player's remaining lives and sequences hit, respawn,
// invulnerability and game-over for the bomberman game.
//
// States:
//   ALIVE  : normal play. A death_signal level takes one life and moves to HIT.
//   HIT    : lasts exactly one cycle. respawn pulses here if lives remain.
//   INVULN : hits are ignored while a frame counter runs down on frame_tick.
//   DEAD   : out of lives. Only restart (or reset) leaves this state.
//
// Parameters:
//   INIT_LIVES    - lives loaded at reset and on restart (1..3)
//   INVULN_FRAMES - invulnerability length in video frames (1..255)
//
// Ports:
//   clk          in   system clock; all state changes on the rising edge
//   reset        in   synchronous active-high reset; overrides every other input
//   death_signal in   level, high while an enemy overlaps bomberman
//   frame_tick   in   single-cycle pulse, once per video frame
//   restart      in   single-cycle pulse from the debounced centre button
//   lives        out  lives remaining
//   respawn      out  single-cycle pulse; bomberman returns to the start tile
//   invuln       out  high while hits are ignored (HIT or INVULN)
//   blink        out  sprite hide request during invulnerability
//   game_over    out  high while out of lives
//
// Optional feature:
//   LIFE_MANAGER_BLINK_EN - when defined, blink follows bit 3 of the frame
//   counter during invulnerability so the sprite toggles every 8 frames.
//   When undefined, blink is tied low and no blink logic exists.
//
// Every output is either a register or a decode of registers only, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module life_manager #(
    parameter int INIT_LIVES    = 3,
    parameter int INVULN_FRAMES = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       death_signal,
    input  logic       frame_tick,
    input  logic       restart,
    output logic [1:0] lives,
    output logic       respawn,
    output logic       invuln,
    output logic       blink,
    output logic       game_over
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        HIT    = 2'd1,
        INVULN = 2'd2,
        DEAD   = 2'd3
    } state_t;

    localparam logic [1:0] INIT_LIVES_VAL = 2'(INIT_LIVES);
    localparam logic [7:0] FRAMES_VAL     = 8'(INVULN_FRAMES);

    state_t     state_reg;
    logic [1:0] lives_reg;
    logic [7:0] count_reg;
    logic       respawn_reg;
    logic       invuln_reg;
    logic       game_over_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ALIVE;
            lives_reg     <= INIT_LIVES_VAL;
            count_reg     <= '0;
            respawn_reg   <= 1'b0;
            invuln_reg    <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            case (state_reg)
                ALIVE: begin
                    // Only the ALIVE->HIT entry costs a life, so a level held
                    // across HIT/INVULN is charged once.
                    if (death_signal) begin
                        state_reg  <= HIT;
                        invuln_reg <= 1'b1;
                        if (lives_reg != 2'd0) begin
                            lives_reg <= lives_reg - 2'd1;
                        end
                        // Respawn only if a life survives this hit.
                        respawn_reg <= (lives_reg > 2'd1);
                    end
                end
                HIT: begin
                    respawn_reg <= 1'b0;
                    if (lives_reg != 2'd0) begin
                        state_reg <= INVULN;
                        count_reg <= FRAMES_VAL;
                    end else begin
                        state_reg     <= DEAD;
                        invuln_reg    <= 1'b0;
                        game_over_reg <= 1'b1;
                    end
                end
                INVULN: begin
                    // Counter saturates at zero; leaving happens on the edge
                    // after it reaches zero, so ticks at zero are ignored.
                    if (count_reg == 8'd0) begin
                        state_reg  <= ALIVE;
                        invuln_reg <= 1'b0;
                    end else if (frame_tick) begin
                        count_reg <= count_reg - 8'd1;
                    end
                end
                DEAD: begin
                    // Restart replays the HIT cycle so the respawn pulse and
                    // the invulnerability window come for free.
                    if (restart) begin
                        state_reg     <= HIT;
                        lives_reg     <= INIT_LIVES_VAL;
                        respawn_reg   <= 1'b1;
                        invuln_reg    <= 1'b1;
                        game_over_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ALIVE;
                end
            endcase
        end
    end

    assign lives     = lives_reg;
    assign respawn   = respawn_reg;
    assign invuln    = invuln_reg;
    assign game_over = game_over_reg;

`ifdef LIFE_MANAGER_BLINK_EN
    // The counter is always zero in HIT (it is only non-zero inside INVULN),
    // so this is low in HIT and tracks counter bit 3 during INVULN.
    assign blink = invuln_reg & count_reg[3];
`else
    assign blink = 1'b0;
`endif

endmodule

// File: doc/life_manager.md
LIFE_MANAGER -- requirements
Module: life_manager

Interface
REQ-001 Parameter INIT_LIVES, default 3, lives loaded at reset and restart; legal range 1..3.
REQ-002 Parameter INVULN_FRAMES, default 120, invulnerability length in frames; legal range 1..255.
REQ-003 clk  input  1  system clock, 100 MHz; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 death_signal  input  1  level; high while any enemy sprite overlaps bomberman.
REQ-006 frame_tick  input  1  single-cycle pulse, once per video frame.
REQ-007 restart  input  1  single-cycle pulse, debounced centre button.
REQ-008 lives  output  2  lives remaining.
REQ-009 respawn  output  1  single-cycle pulse; bomberman returns to start tile.
REQ-010 invuln  output  1  high while hits are ignored.
REQ-011 blink  output  1  bomberman sprite hide request during invulnerability.
REQ-012 game_over  output  1  high while out of lives; drives the green full-screen fill.

Function
REQ-013 The block SHALL implement FSM states ALIVE, HIT, INVULN, DEAD, held in a state register.
REQ-014 ALIVE: death_signal=1 at edge k -> state=HIT and lives=lives-1 at edge k+1; death_signal=0 -> stay.
REQ-015 HIT (exactly one cycle): lives!=0 -> INVULN with frame counter loaded to INVULN_FRAMES; lives==0 -> DEAD.
REQ-016 respawn SHALL be high exactly during the HIT cycle when lives!=0, and low otherwise.
REQ-017 INVULN: each frame_tick decrements the 8-bit frame counter; when the counter reaches 0, state -> ALIVE on the next edge; death_signal is ignored.
REQ-018 The frame counter SHALL NOT wrap: it saturates at 0, and frame_tick is ignored at 0.
REQ-019 DEAD is sticky; death_signal and frame_tick are ignored there.
REQ-020 restart in DEAD -> next edge: lives=INIT_LIVES, state=HIT-equivalent respawn pulse for one cycle, then INVULN with counter=INVULN_FRAMES.
REQ-021 restart SHALL be ignored in ALIVE, HIT and INVULN.
REQ-022 invuln = (state==HIT or INVULN); game_over = (state==DEAD); both decoded from registered state only, with no input-to-output combinational path.
REQ-023 If death_signal and frame_tick coincide in ALIVE, the hit SHALL be taken.
REQ-024 A continuous death_signal level SHALL cost exactly one life per ALIVE->HIT entry, never one per cycle.
REQ-025 lives SHALL never underflow below 0.

Reset
REQ-026 reset=1 at any edge, including mid-INVULN and in DEAD, SHALL force state=ALIVE, lives=INIT_LIVES, frame counter=0 and blink phase=0.
REQ-027 After reset, respawn=0, invuln=0, blink=0 and game_over=0.
REQ-028 reset SHALL take priority over all other inputs.

Configuration
REQ-029 Macro LIFE_MANAGER_BLINK_EN defined: blink = invuln AND frame counter bit 3, so the sprite toggles every 8 frames during INVULN; blink=0 in HIT.
REQ-030 Macro LIFE_MANAGER_BLINK_EN undefined: blink is constant 0, and no blink logic is synthesized.

Verification (bench uses INIT_LIVES=3, INVULN_FRAMES=4)
REQ-031 Reset, then death_signal held high 3 cycles -> lives 3->2 one cycle later; respawn is one cycle high; invuln=1; lives stays 2 throughout.
REQ-032 In INVULN, 4 frame_ticks -> invuln falls one cycle after the 4th tick; with death_signal still high, lives=1 two cycles later.
REQ-033 Three separate hits from reset -> lives=0, game_over=1 with no respawn pulse; then 10 frame_ticks plus death_signal high -> game_over remains 1.
REQ-034 In DEAD, restart pulse -> lives=3, respawn one cycle, invuln=1, game_over=0.
REQ-035 In INVULN (counter=2), assert reset -> next cycle lives=3, invuln=0, blink=0, state ALIVE.
REQ-036 Same-cycle death_signal and frame_tick in ALIVE -> hit taken (lives decrements); with BLINK_EN and INVULN_FRAMES=16, blink is high for frame counter values 15..8 and low for 7..0.
